// File: rtl/cluster_rate_generator_pkg.sv
// Shared types and constants for the synthetic cluster-count source.
package cluster_rate_generator_pkg;

  // Fabric clock of the LHC-synchronous trigger path, in Hz.
  localparam int unsigned C_CLK_FREQ_LHC = 32'd40000000;

  // Default datapath widths.
  localparam int C_COUNT_WIDTH = 8;
  localparam int C_BURST_WIDTH = 16;
  localparam int C_RATE_WIDTH  = 32;

  // Generator control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Requested rates above the clock frequency saturate to one event per cycle.
  function automatic logic [31:0] clamp_rate(input logic [31:0] rate,
                                             input logic [31:0] limit);
    logic [31:0] result;
    if (rate > limit) begin
      result = limit;
    end else begin
      result = rate;
    end
    return result;
  endfunction

endpackage

// File: rtl/cluster_rate_generator_rate_phase_acc.sv
// Phase accumulator: adds step every cycle and signals a fire whenever the
// running sum reaches the modulus, keeping the remainder so the long-run
// average fire rate is exactly step/modulus per cycle.
import cluster_rate_generator_pkg::*;

module rate_phase_acc #(
  parameter logic [31:0] g_MODULUS = 32'd40000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [31:0] step,
  output logic        fire
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [32:0] sum_s;
  logic [32:0] diff_s;
  logic        reach_s;

  // Sum is 33 bits wide so acc + step can never wrap before the compare.
  always_comb begin
    sum_s   = {1'b0, acc_q} + {1'b0, step};
    diff_s  = sum_s - {1'b0, g_MODULUS};
    reach_s = (sum_s >= {1'b0, g_MODULUS});
    acc_d   = acc_q;
    fire    = 1'b0;
    if (clear) begin
      acc_d = 32'd0;
      fire  = 1'b0;
    end else if (reach_s) begin
      // acc < modulus and step <= modulus, so the remainder fits 32 bits.
      acc_d = diff_s[31:0];
      fire  = 1'b1;
    end else begin
      acc_d = sum_s[31:0];
      fire  = 1'b0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= 32'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/cluster_rate_generator.sv
// Synthetic cluster-count source: emits multiplicity clusters on each event
// at a programmed rate, continuously or as a fixed-length burst.
import cluster_rate_generator_pkg::*;

module cluster_rate_generator #(
  parameter int unsigned g_CLK_FREQUENCY = C_CLK_FREQ_LHC,
  parameter int          g_COUNT_WIDTH   = C_COUNT_WIDTH,
  parameter int          g_BURST_WIDTH   = C_BURST_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     burst_mode,
  input  logic [31:0]              target_rate,
  input  logic [g_COUNT_WIDTH-1:0] multiplicity,
  input  logic [g_BURST_WIDTH-1:0] burst_length,
  output logic [g_COUNT_WIDTH-1:0] cluster_count,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              events_sent
);

  localparam logic [31:0] C_MODULUS = 32'(g_CLK_FREQUENCY);

  state_e                   state_q, state_d;
  logic [31:0]              rate_q, rate_d;
  logic [g_COUNT_WIDTH-1:0] mult_q, mult_d;
  logic [g_BURST_WIDTH-1:0] blen_q, blen_d;
  logic                     bmode_q, bmode_d;
  logic [g_BURST_WIDTH-1:0] evcnt_q, evcnt_d;
  logic [g_COUNT_WIDTH-1:0] cluster_count_q, cluster_count_d;
  logic [31:0]              events_sent_q, events_sent_d;

  logic [31:0]              rate_l_s;
  logic [31:0]              step_s;
  logic                     acc_clear_s;
  logic                     fire_s;
  logic [g_BURST_WIDTH-1:0] evcnt_inc_s;

  // The accumulator only advances while running and enabled; an enable drop
  // in RUN therefore can never produce an event on the exit edge. It is held
  // cleared in IDLE so every start begins from phase zero.
  assign rate_l_s    = clamp_rate(rate_q, C_MODULUS);
  assign step_s      = ((state_q == ST_RUN) && enable) ? rate_l_s : 32'd0;
  assign acc_clear_s = (state_q == ST_IDLE);
  assign evcnt_inc_s = evcnt_q + g_BURST_WIDTH'(1);

  rate_phase_acc #(
    .g_MODULUS (C_MODULUS)
  ) u_rate_phase_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (acc_clear_s),
    .step    (step_s),
    .fire    (fire_s)
  );

  // Next-state, configuration latching, event counting and output data.
  always_comb begin
    state_d         = state_q;
    rate_d          = rate_q;
    mult_d          = mult_q;
    blen_d          = blen_q;
    bmode_d         = bmode_q;
    evcnt_d         = evcnt_q;
    events_sent_d   = events_sent_q;
    cluster_count_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          rate_d        = target_rate;
          mult_d        = multiplicity;
          blen_d        = burst_length;
          bmode_d       = burst_mode;
          evcnt_d       = '0;
          events_sent_d = 32'd0;
          if (burst_mode && (burst_length == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fire_s) begin
          cluster_count_d = mult_q;
          events_sent_d   = events_sent_q + 32'd1;
          evcnt_d         = evcnt_inc_s;
          if (bmode_q && (evcnt_inc_s == blen_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      rate_q          <= 32'd0;
      mult_q          <= '0;
      blen_q          <= '0;
      bmode_q         <= 1'b0;
      evcnt_q         <= '0;
      cluster_count_q <= '0;
      events_sent_q   <= 32'd0;
    end else begin
      state_q         <= state_d;
      rate_q          <= rate_d;
      mult_q          <= mult_d;
      blen_q          <= blen_d;
      bmode_q         <= bmode_d;
      evcnt_q         <= evcnt_d;
      cluster_count_q <= cluster_count_d;
      events_sent_q   <= events_sent_d;
    end
  end

  assign cluster_count = cluster_count_q;
  assign events_sent   = events_sent_q;
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_cluster_rate_generator.sv
// Directed self-checking bench for cluster_rate_generator.
module tb_cluster_rate_generator;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        burst_mode;
  logic [31:0] target_rate;
  logic [7:0]  multiplicity;
  logic [15:0] burst_length;
  logic [7:0]  cluster_count;
  logic        busy;
  logic        done;
  logic [31:0] events_sent;

  int total;
  int bad;

  typedef struct {
    logic [31:0] rate;
    logic [7:0]  mult;
    logic        bmode;
    logic [15:0] blen;
    int          ncyc;
    int          exp_ev;
    int          exp_first;
    int          exp_nz;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [9];

  cluster_rate_generator dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .burst_mode    (burst_mode),
    .target_rate   (target_rate),
    .multiplicity  (multiplicity),
    .burst_length  (burst_length),
    .cluster_count (cluster_count),
    .busy          (busy),
    .done          (done),
    .events_sent   (events_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drop enable long enough to return to IDLE, load config, then raise enable.
  task automatic start_cfg(input logic [31:0] rate, input logic [7:0] mult,
                           input logic bmode, input logic [15:0] blen);
    enable = 1'b0;
    tick();
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    target_rate  = rate;
    multiplicity = mult;
    burst_mode   = bmode;
    burst_length = blen;
    enable       = 1'b1;
  endtask

  // Watch n edges; k counts edges since enable went high (k=1 is the start edge).
  task automatic run_watch(input int n, input logic [7:0] mult,
                           output int first, output int nz, output int badv);
    first = 0;
    nz    = 0;
    badv  = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (cluster_count != 8'd0) begin
        nz = nz + 1;
        if (first == 0) first = k;
        if (cluster_count != mult) badv = badv + 1;
      end
    end
  endtask

  initial begin
    int first;
    int nz;
    int badv;
    total = 0;
    bad   = 0;

    //            rate           mult  bm    blen    ncyc  ev    first nz    busy  done
    vecs[0] = '{32'd10000000,  8'd3, 1'b0, 16'd0,  4001, 1000, 5,    1000, 1'b1, 1'b0};
    vecs[1] = '{32'd40000000,  8'd1, 1'b1, 16'd5,  10,   5,    2,    5,    1'b0, 1'b1};
    vecs[2] = '{32'd0,         8'd7, 1'b0, 16'd0,  50,   0,    0,    0,    1'b1, 1'b0};
    vecs[3] = '{32'hFFFFFFFF,  8'd2, 1'b0, 16'd0,  20,   19,   2,    19,   1'b1, 1'b0};
    vecs[4] = '{32'd20000,     8'd4, 1'b0, 16'd0,  6001, 3,    2001, 3,    1'b1, 1'b0};
    vecs[5] = '{32'd10000000,  8'd9, 1'b1, 16'd0,  2,    0,    0,    0,    1'b0, 1'b1};
    vecs[6] = '{32'd40000000,  8'd0, 1'b0, 16'd0,  10,   9,    0,    0,    1'b1, 1'b0};
    vecs[7] = '{32'd13000000,  8'd5, 1'b0, 16'd0,  11,   3,    5,    3,    1'b1, 1'b0};
    vecs[8] = '{32'd10000000,  8'd2, 1'b1, 16'd3,  20,   3,    5,    3,    1'b0, 1'b1};

    reset_n      = 1'b0;
    enable       = 1'b0;
    burst_mode   = 1'b0;
    target_rate  = 32'd0;
    multiplicity = 8'd0;
    burst_length = 16'd0;
    tick();
    tick();
    check("rst_cc",     {24'd0, cluster_count}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_events", events_sent, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      start_cfg(vecs[v].rate, vecs[v].mult, vecs[v].bmode, vecs[v].blen);
      run_watch(vecs[v].ncyc, vecs[v].mult, first, nz, badv);
      check($sformatf("v%0d_events", v), events_sent, vecs[v].exp_ev);
      check($sformatf("v%0d_first", v), first, vecs[v].exp_first);
      check($sformatf("v%0d_nz", v), nz, vecs[v].exp_nz);
      check($sformatf("v%0d_value", v), badv, 32'd0);
      check($sformatf("v%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].exp_busy});
      check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
    end

    // Burst re-trigger: events_sent restarts and a fresh 5-event burst follows.
    start_cfg(32'd40000000, 8'd1, 1'b1, 16'd5);
    run_watch(10, 8'd1, first, nz, badv);
    check("burst1_done", {31'd0, done}, 32'd1);
    start_cfg(32'd40000000, 8'd1, 1'b1, 16'd5);
    run_watch(10, 8'd1, first, nz, badv);
    check("burst2_nz", nz, 32'd5);
    check("burst2_events", events_sent, 32'd5);
    check("burst2_done", {31'd0, done}, 32'd1);

    // Mid-run rate change is ignored until the next start.
    start_cfg(32'd10000000, 8'd3, 1'b0, 16'd0);
    tick();
    tick();
    target_rate = 32'd40000000;
    run_watch(11, 8'd3, first, nz, badv);
    check("chg_events", events_sent, 32'd3);
    check("chg_nz", nz, 32'd3);
    start_cfg(32'd40000000, 8'd3, 1'b0, 16'd0);
    run_watch(5, 8'd3, first, nz, badv);
    check("chg2_events", events_sent, 32'd4);

    // Enable drop in RUN: no event on the exit edge.
    start_cfg(32'd40000000, 8'd6, 1'b0, 16'd0);
    run_watch(3, 8'd6, first, nz, badv);
    check("stop_pre_events", events_sent, 32'd2);
    enable = 1'b0;
    tick();
    check("stop_cc", {24'd0, cluster_count}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_events", events_sent, 32'd2);

    // Asynchronous reset in the middle of a full-rate run.
    start_cfg(32'd40000000, 8'd1, 1'b0, 16'd0);
    run_watch(5, 8'd1, first, nz, badv);
    check("pre_rst_cc", {24'd0, cluster_count}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_cc", {24'd0, cluster_count}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_events", events_sent, 32'd0);
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    check("post_rst_events", events_sent, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
